uart_rx_frame: RTL
==================

# uart_rx_frame

UART receive framer that sits directly upstream of the receive parity checker. It oversamples the serial line and detects the start bit, then shifts data in LSB-first. It presents the captured word and the sampled parity bit to the checker with a one-cycle load strobe, captures the checker's error verdict, validates the stop bit, and emits one word per frame with error flags.

## Interface
- `DATA_WIDTH`, default `` `DATA_WIDTH `` (8): data bits per frame; also the width of `parallel_out`.
- `OVERSAMPLE`, default 16: `baud_tick` pulses per bit. Must be an even number, at least 4.
- `clk`  in  1  single clock; every register is clocked on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `baud_tick`  in  1  one-`clk`-wide enable at OVERSAMPLE × baud rate.
- `rx`  in  1  asynchronous serial line; idles high.
- `parity_en`  in  1  1 = frame carries a parity bit. Sampled at start detection.
- `parity_bit_error`  in  1  error verdict from the parity checker.
- `parity_load`  out  1  one-cycle strobe to the checker.
- `rx_bit`  out  1  sampled parity bit, fed to the checker's `rx_in`.
- `parallel_out`  out  DATA_WIDTH  shift register contents; fed to the checker's `parallel_in`.
- `data_valid`  out  1  one-cycle pulse: frame complete.
- `parity_error`  out  1  parity verdict for the last frame; valid with `data_valid`.
- `frame_error`  out  1  stop bit was sampled low; valid with `data_valid`.
- `busy`  out  1  high in every state except IDLE.

## Operation
- `rx` passes through a 2-flop synchronizer (`rx_s`). Both flops reset to 1. `rx_d` is `rx_s` delayed by one flop and is used for edge detection.
- Internal state:
  - `tick_cnt`, width $clog2(OVERSAMPLE).
  - `bit_cnt`, width $clog2(DATA_WIDTH+1).
  - `par_flag`, the stored parity verdict.
  - `par_on`, the latched copy of `parity_en`.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - Start is detected on a falling edge (`rx_d`=1, `rx_s`=0); no `baud_tick` is needed.
  - On detection: go to START, `tick_cnt`←0, `bit_cnt`←0, `par_flag`←0, `par_on`←`parity_en`.
  - A line held low (break) never retriggers; a new falling edge is required.
- START, on each `baud_tick`:
  - At `tick_cnt`=OVERSAMPLE/2−1 (mid-bit), with `tick_cnt`←0: if `rx_s`=0 go to DATA; else treat as a false start and go to IDLE.
  - Otherwise `tick_cnt`++.
- DATA, PARITY and STOP share one sampling rule: the bit is sampled on a `baud_tick` when `tick_cnt`=OVERSAMPLE−1, with `tick_cnt`←0. Otherwise `tick_cnt`++ on `baud_tick`.
- DATA, at each sample:
  - Shift LSB-first: `parallel_out` ← {`rx_s`, `parallel_out`[DATA_WIDTH−1:1]}, then `bit_cnt`++.
  - After the DATA_WIDTH-th bit: go to PARITY if `par_on`, else STOP.
- PARITY, at the sample:
  - `rx_bit`←`rx_s`, `parity_load`←1 (registered, so high during the next cycle), go to STOP.
  - In the cycle where `parity_load`=1: `par_flag`←`parity_bit_error` at the end of that cycle, and `parity_load`←0.
- STOP, at the sample:
  - `data_valid`←1 for exactly one cycle.
  - `frame_error`←~`rx_s`.
  - `parity_error`←`par_flag` (always 0 when `par_on`=0).
  - Go to IDLE.
- `parallel_out`, `parity_error` and `frame_error` hold their values until the next frame's updates.
- Checker contract: the checker flags an error when `rx_in` equals the XOR of the data, so the line carries odd parity.
- Changing `parity_en` mid-frame has no effect on the frame in progress.

## Timing
- Reset values: state IDLE; `parallel_out`=0; `rx_bit`=0; all single-bit outputs 0 (`parity_load`, `data_valid`, `parity_error`, `frame_error`, `busy`).
- Synchronizer latency: 2 `clk` from `rx` to `rx_s`.
- Start detection to `data_valid`: (OVERSAMPLE/2 + (DATA_WIDTH + par_on + 1)·OVERSAMPLE) `baud_tick`s, plus 1 `clk`.
- Spacing guarantee: `parity_load` rises at least OVERSAMPLE `baud_tick`s before the STOP sample. Therefore `par_flag` is always settled before `data_valid`.
- `baud_tick` while `parity_load`=1: the counter still advances.
- Mid-frame `rst`: all state clears immediately. No `data_valid` is produced for the aborted frame, and the next falling edge starts a fresh frame.
- Back-to-back frames: a start edge is accepted in the `clk` after `data_valid`.

## Test plan
- OVERSAMPLE=16, `parity_en`=1, send 0xA5 with parity bit 1 and stop bit 1 → exactly one `data_valid` pulse; `parallel_out`=0xA5, `parity_error`=0, `frame_error`=0. Checker sees `parity_load` for 1 cycle with `rx_bit`=1.
- Same frame with parity bit 0 → `parallel_out`=0xA5, `parity_error`=1, `frame_error`=0.
- `parity_en`=0, send 0x3C with stop bit 0 → `parallel_out`=0x3C, `frame_error`=1, `parity_error`=0, `parity_load` never asserted. Line then held low for 3 frames → no further `data_valid`.
- Glitch: `rx` low for 4 `baud_tick`s, then high → returns to IDLE, no `data_valid`, `busy` drops. A following valid 0x81 frame is received correctly.
- Assert `rst` during the 4th data bit of 0xFF → all outputs 0 immediately, no `data_valid`. A next frame of 0x12 is received correctly.
- Two back-to-back frames 0x55 then 0xAA (parity on, correct parity) → two `data_valid` pulses with `parallel_out` 0x55 then 0xAA; no errors.

Source files
------------

// File: rtl/uart_rx_frame.sv
// UART receive framer: oversampled start detect, LSB-first shift, parity
// hand-off to an external checker, stop-bit check and per-frame flags.
//
// Ports:
//   clk, rst           clock, async active-high reset
//   baud_tick          OVERSAMPLE x baud enable
//   rx                 serial line (async, idles high)
//   parity_en          frame carries a parity bit (latched at start)
//   parity_bit_error   checker verdict, captured while parity_load is high
//   parity_load        one-cycle strobe to the checker
//   rx_bit             sampled parity bit for the checker
//   parallel_out       received word
//   data_valid         one-cycle frame-complete pulse
//   parity_error       parity verdict, valid with data_valid
//   frame_error        stop bit sampled low, valid with data_valid
//   busy               not idle

`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module uart_rx_frame #(
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int OVERSAMPLE = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  baud_tick,
  input  logic                  rx,
  input  logic                  parity_en,
  input  logic                  parity_bit_error,
  output logic                  parity_load,
  output logic                  rx_bit,
  output logic [DATA_WIDTH-1:0] parallel_out,
  output logic                  data_valid,
  output logic                  parity_error,
  output logic                  frame_error,
  output logic                  busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_WIDTH + 1);

  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e state_q, state_d;

  logic rx_meta_q, rx_s_q, rx_d_q;

  logic [TW-1:0]         tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic                  par_flag_q, par_flag_d;
  logic                  par_on_q, par_on_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  rx_bit_q, rx_bit_d;
  logic                  load_q, load_d;
  logic                  valid_q, valid_d;
  logic                  perr_q, perr_d;
  logic                  ferr_q, ferr_d;

  logic sample;
  logic start_edge;

  // Synchronizer and edge-detect flops idle high like the line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_d_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      rx_d_q    <= rx_s_q;
    end
  end

  assign sample     = baud_tick && (tick_cnt_q == TICK_LAST);
  assign start_edge = rx_d_q && !rx_s_q;

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    par_flag_d = par_flag_q;
    par_on_d   = par_on_q;
    shift_d    = shift_q;
    rx_bit_d   = rx_bit_q;
    load_d     = 1'b0;
    valid_d    = 1'b0;
    perr_d     = perr_q;
    ferr_d     = ferr_q;

    // Checker answers combinationally during the strobe cycle.
    if (load_q) begin
      par_flag_d = parity_bit_error;
    end

    unique case (state_q)
      S_IDLE: begin
        if (start_edge) begin
          state_d    = S_START;
          tick_cnt_d = '0;
          bit_cnt_d  = '0;
          par_flag_d = 1'b0;
          par_on_d   = parity_en;
        end
      end
      S_START: begin
        if (baud_tick) begin
          if (tick_cnt_q == TICK_MID) begin
            tick_cnt_d = '0;
            state_d    = rx_s_q ? S_IDLE : S_DATA;
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end
      end
      S_DATA: begin
        if (sample) begin
          tick_cnt_d = '0;
          shift_d    = {rx_s_q, shift_q[DATA_WIDTH-1:1]};
          bit_cnt_d  = bit_cnt_q + BW'(1);
          if (bit_cnt_q == BIT_LAST) begin
            state_d = par_on_q ? S_PARITY : S_STOP;
          end
        end else if (baud_tick) begin
          tick_cnt_d = tick_cnt_q + TW'(1);
        end
      end
      S_PARITY: begin
        if (sample) begin
          tick_cnt_d = '0;
          rx_bit_d   = rx_s_q;
          load_d     = 1'b1;
          state_d    = S_STOP;
        end else if (baud_tick) begin
          tick_cnt_d = tick_cnt_q + TW'(1);
        end
      end
      S_STOP: begin
        if (sample) begin
          tick_cnt_d = '0;
          valid_d    = 1'b1;
          ferr_d     = !rx_s_q;
          perr_d     = par_flag_q;
          state_d    = S_IDLE;
        end else if (baud_tick) begin
          tick_cnt_d = tick_cnt_q + TW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      par_flag_q <= 1'b0;
      par_on_q   <= 1'b0;
      shift_q    <= '0;
      rx_bit_q   <= 1'b0;
      load_q     <= 1'b0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      par_flag_q <= par_flag_d;
      par_on_q   <= par_on_d;
      shift_q    <= shift_d;
      rx_bit_q   <= rx_bit_d;
      load_q     <= load_d;
      valid_q    <= valid_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
    end
  end

  assign parity_load  = load_q;
  assign rx_bit       = rx_bit_q;
  assign parallel_out = shift_q;
  assign data_valid   = valid_q;
  assign parity_error = perr_q;
  assign frame_error  = ferr_q;
  assign busy         = (state_q != S_IDLE);

endmodule
